// File: rtl/pll_rst_seq.sv
// pll_rst_seq: staged reset sequencer in the PLL output clock domain.
//
// Synchronises the PLL lock flag, waits for lock to stay high for a
// stability window, then releases the core reset and, later, the
// peripheral reset. Any lock loss after the window has passed sends the
// sequence back to HOLD and bumps a saturating lock-loss counter.
//
// Optional feature (macro PLL_RST_SEQ_TICK_EN): a fractional-rate
// accumulator emits a one-cycle tick at an average rate TICK_HZ while in
// RUN. Without the macro no accumulator is built and tick is tied low.
//
// Ports:
//   clk            PLL output clock (single clock domain)
//   rst            synchronous active-high reset, already in clk domain
//   pll_lock       PLL lock flag, asynchronous to clk
//   rst_core       active-high core reset (registered)
//   rst_periph     active-high peripheral reset (registered)
//   ready          high when the sequence has completed (RUN)
//   lock_loss_cnt  saturating count of lock losses after sequencing began
//   tick           one-cycle strobe at average rate TICK_HZ

module pll_rst_seq #(
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned CORE_DLY    = 16,
  parameter int unsigned PERIPH_DLY  = 64,
  parameter int unsigned CLK_HZ      = 94500000,
  parameter int unsigned TICK_HZ     = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic       tick
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LLC_W = 8;
  localparam int unsigned ACC_W = 32;

  localparam logic [CNT_W-1:0] LOCK_TERM   = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CORE_TERM   = CNT_W'(CORE_DLY - 1);
  localparam logic [CNT_W-1:0] PERIPH_TERM = CNT_W'(PERIPH_DLY - 1);
  localparam logic [LLC_W-1:0] LLC_MAX     = {LLC_W{1'b1}};

  // Elaboration-time parameter range guards.
  if ((LOCK_STABLE < 1) || (LOCK_STABLE > 65535)) begin : g_bad_lock_stable
    $error("pll_rst_seq: LOCK_STABLE out of range 1..65535");
  end
  if ((CORE_DLY < 1) || (CORE_DLY > 65535)) begin : g_bad_core_dly
    $error("pll_rst_seq: CORE_DLY out of range 1..65535");
  end
  if ((PERIPH_DLY < 1) || (PERIPH_DLY > 65535)) begin : g_bad_periph_dly
    $error("pll_rst_seq: PERIPH_DLY out of range 1..65535");
  end
  if ((TICK_HZ == 0) || (TICK_HZ >= CLK_HZ) || (CLK_HZ >= 32'h8000_0000)) begin : g_bad_tick
    $error("pll_rst_seq: require 0 < TICK_HZ < CLK_HZ < 2^31");
  end

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    CORE_WAIT   = 2'd1,
    PERIPH_WAIT = 2'd2,
    RUN         = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lock_meta;
  logic             lock_s;
  logic             lock_lost_c;
  logic             rst_core_c;
  logic             rst_periph_c;
  logic             ready_c;
  logic [LLC_W-1:0] llc_c;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk) begin : p_lock_sync
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State and window counter registers.
  always_ff @(posedge clk) begin : p_state_reg
    if (rst) begin
      state <= HOLD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; lock loss outranks a terminal count in the same cycle.
  always_comb begin : p_next_state
    state_nxt   = state;
    cnt_nxt     = cnt;
    lock_lost_c = 1'b0;
    case (state)
      HOLD: begin
        if (!lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_TERM) begin
          state_nxt = CORE_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      CORE_WAIT: begin
        if (!lock_s) begin
          state_nxt   = HOLD;
          cnt_nxt     = '0;
          lock_lost_c = 1'b1;
        end else if (cnt == CORE_TERM) begin
          state_nxt = PERIPH_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PERIPH_WAIT: begin
        if (!lock_s) begin
          state_nxt   = HOLD;
          cnt_nxt     = '0;
          lock_lost_c = 1'b1;
        end else if (cnt == PERIPH_TERM) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt   = HOLD;
          cnt_nxt     = '0;
          lock_lost_c = 1'b1;
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the
  // state register on the same edge.
  always_comb begin : p_out_dec
    rst_core_c   = (state_nxt == HOLD) || (state_nxt == CORE_WAIT);
    rst_periph_c = (state_nxt != RUN);
    ready_c      = (state_nxt == RUN);
    llc_c        = lock_loss_cnt;
    if (lock_lost_c && (lock_loss_cnt != LLC_MAX)) begin
      llc_c = lock_loss_cnt + LLC_W'(1);
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin : p_out_reg
    if (rst) begin
      rst_core      <= 1'b1;
      rst_periph    <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      rst_core      <= rst_core_c;
      rst_periph    <= rst_periph_c;
      ready         <= ready_c;
      lock_loss_cnt <= llc_c;
    end
  end

`ifdef PLL_RST_SEQ_TICK_EN
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum_c;
  logic             run_c;

  // Accumulate only while staying in RUN; any exit clears the phase.
  assign acc_sum_c = acc + ACC_W'(TICK_HZ);
  assign run_c     = (state == RUN) && (state_nxt == RUN);

  // Fractional tick: add TICK_HZ per cycle, wrap modulo CLK_HZ.
  always_ff @(posedge clk) begin : p_tick
    if (rst || !run_c) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_sum_c >= ACC_W'(CLK_HZ)) begin
      acc  <= acc_sum_c - ACC_W'(CLK_HZ);
      tick <= 1'b1;
    end else begin
      acc  <= acc_sum_c;
      tick <= 1'b0;
    end
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset sequencer in the PLL output clock domain (94.5 MHz from the 27 MHz board clock).
- Synchronises the PLL lock flag and requires lock to be stable for a set window.
- Releases the core reset first and the peripheral reset later, in stages.
- Counts lock-loss events and, when the optional feature is compiled in, emits a fractional-rate 1 µs tick for downstream timers.

Parameters:
- LOCK_STABLE, 1024: consecutive synchronised lock-high cycles required before sequencing (1..65535).
- CORE_DLY, 16: cycles from lock-stable to core reset release (1..65535).
- PERIPH_DLY, 64: cycles from core release to peripheral release (1..65535).
- CLK_HZ, 94500000: clk frequency, used by the tick generator.
- TICK_HZ, 1000000: tick rate; must be less than CLK_HZ.

Ports:
- clk  in  1  PLL output clock; single clock domain.
- rst  in  1  synchronous active-high reset (external/button, already in the clk domain).
- pll_lock  in  1  PLL lock flag; asynchronous to clk.
- rst_core  out  1  active-high core reset, registered.
- rst_periph  out  1  active-high peripheral reset, registered.
- ready  out  1  high when the sequence is complete (state RUN).
- lock_loss_cnt  out  8  saturating count of lock losses after sequencing began.
- tick  out  1  one-cycle strobe at the average rate TICK_HZ.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Effect of rst: state=HOLD, cnt=0, both sync flops=0, lock_loss_cnt=0, tick accumulator=0. Outputs after rst: rst_core=1, rst_periph=1, ready=0, tick=0.
- rst mid-sequence: same effect as above, applied at the next edge, regardless of state.
- Lock synchroniser: 2-flop; lock_s = second flop. Latency is 2 edges.
- Internal counter cnt: 16 bits.
- Registered outputs are decoded from the next state:
  - rst_core = (state in {HOLD, CORE_WAIT})
  - rst_periph = (state != RUN)
  - ready = (state == RUN)
- HOLD:
  - lock_s=0 -> cnt=0.
  - lock_s=1 and cnt==LOCK_STABLE-1 -> CORE_WAIT, cnt=0.
  - Otherwise cnt++.
- CORE_WAIT: cnt==CORE_DLY-1 -> PERIPH_WAIT, cnt=0; otherwise cnt++.
- PERIPH_WAIT: cnt==PERIPH_DLY-1 -> RUN, cnt=0; otherwise cnt++.
- RUN: hold.
- Lock loss: lock_s=0 in CORE_WAIT, PERIPH_WAIT or RUN -> HOLD at the next edge, cnt=0. Both resets reassert at that edge. lock_loss_cnt increments, saturating at 255.
  - Lock loss has priority over the counter-terminal transition in the same cycle.
  - lock_s=0 in HOLD is not counted.
- Release timing: pll_lock sampled high at edge E and held high -> rst_core falls at edge E+1+LOCK_STABLE+CORE_DLY, rst_periph falls PERIPH_DLY edges later.
- Lock glitch: a single-cycle low on lock_s during HOLD restarts the stability window from zero.
- Tick generator (32-bit accumulator acc, active only in RUN; acc=0 and tick=0 in any other state):
  - Each cycle: s = acc + TICK_HZ.
  - If s >= CLK_HZ: acc = s - CLK_HZ, tick=1 (registered).
  - Else: acc = s, tick=0.
  - After n RUN cycles, total ticks = floor(n*TICK_HZ/CLK_HZ).
  - Widths: no overflow, since CLK_HZ < 2^31.

Optional Feature:
- Macro: PLL_RST_SEQ_TICK_EN.
- Defined: the tick accumulator and tick output behave as specified above.
- Undefined: no accumulator logic is built; tick is tied to 0. All other behaviour is identical.

Test Plan:
- LOCK_STABLE=8, CORE_DLY=4, PERIPH_DLY=4; pll_lock rises, first sampled at edge 10 -> rst_core falls at edge 23, rst_periph and ready rise/fall together at edge 27, lock_loss_cnt=0.
- Same params; pll_lock low for 1 cycle 5 edges into the HOLD window -> window restarts; release is delayed by exactly the elapsed count plus sync latency; lock_loss_cnt=0.
- In RUN, drop pll_lock for 3 cycles -> 2 edges after the drop, rst_core=rst_periph=1 and ready=0; lock_loss_cnt=1; full sequence repeats after relock.
- Force 300 lock losses -> lock_loss_cnt saturates at 255, no wrap.
- PLL_RST_SEQ_TICK_EN defined, defaults: first tick on RUN cycle 95; exactly 2 ticks in 189 RUN cycles; 1000 ticks in 94500 cycles. Undefined: tick stays 0.
- Assert rst during PERIPH_WAIT -> next edge rst_core=1, rst_periph=1, ready=0, lock_loss_cnt=0; sequence restarts from HOLD with a fresh 2-flop latency.
